// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: sequential byte fetcher for a registered-output ROM.
// Drives a single-cycle read strobe and captures the returned byte.
// Presents the byte with its source address on a valid/ready handshake.
// A jump reloads the program counter and discards any fetch in progress.
module rom_fetch_unit #(
    parameter int unsigned ADDR_W     = 32'd4,
    parameter int unsigned DATA_W     = 32'd8,
    parameter int unsigned START_ADDR = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(32'd1);

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_s;
    logic [ADDR_W-1:0]   fetch_pc_r;
    logic [ADDR_W-1:0]   fetch_pc_s;
    logic                cancel_r;      // fetch issued in a jump cycle; drop its data
    logic                cancel_s;
    logic                rom_rd_r;
    logic [DATA_W-1:0]   instr_data_r;
    logic [DATA_W-1:0]   instr_data_s;
    logic [ADDR_W-1:0]   instr_pc_r;
    logic [ADDR_W-1:0]   instr_pc_s;
    logic                instr_valid_r;
    logic                instr_valid_s;

    // Next-state, program counter and output-register logic.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        fetch_pc_s    = fetch_pc_r;
        cancel_s      = cancel_r;
        instr_data_s  = instr_data_r;
        instr_pc_s    = instr_pc_r;
        instr_valid_s = instr_valid_r;

        case (state_r)
            S_IDLE: begin
                instr_valid_s = 1'b0;
                cancel_s      = 1'b0;
                if (run) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_ISSUE: begin
                fetch_pc_s = pc_r;
                state_s    = S_CAPTURE;
                if (jump_en) begin
                    cancel_s = 1'b1;
                end else begin
                    cancel_s = 1'b0;
                    pc_s     = pc_r + PC_ONE;
                end
            end

            S_CAPTURE: begin
                cancel_s = 1'b0;
                if (jump_en || cancel_r) begin
                    // Returned byte belongs to an abandoned address stream.
                    instr_valid_s = 1'b0;
                    state_s       = S_ISSUE;
                end else begin
                    instr_data_s  = rom_data;
                    instr_pc_s    = fetch_pc_r;
                    instr_valid_s = 1'b1;
                    state_s       = S_HOLD;
                end
            end

            S_HOLD: begin
                if (jump_en) begin
                    // Jump wins over a simultaneous accept: byte is not delivered.
                    instr_valid_s = 1'b0;
                    state_s       = S_ISSUE;
                end else if (instr_ready) begin
                    instr_valid_s = 1'b0;
                    if (run) begin
                        state_s = S_ISSUE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_HOLD;
                end
            end

            default: begin
                state_s       = S_IDLE;
                instr_valid_s = 1'b0;
                cancel_s      = 1'b0;
            end
        endcase

        // A jump overrides any increment in every state.
        if (jump_en) begin
            pc_s = jump_addr;
        end else begin
            pc_s = pc_s;
        end
    end

    // State, address and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            pc_r          <= START_PC;
            fetch_pc_r    <= '0;
            cancel_r      <= 1'b0;
            rom_rd_r      <= 1'b0;
            instr_data_r  <= '0;
            instr_pc_r    <= '0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            fetch_pc_r    <= fetch_pc_s;
            cancel_r      <= cancel_s;
            rom_rd_r      <= (state_s == S_ISSUE);
            instr_data_r  <= instr_data_s;
            instr_pc_r    <= instr_pc_s;
            instr_valid_r <= instr_valid_s;
        end
    end

    assign rom_rd      = rom_rd_r;
    assign rom_addr    = pc_r;
    assign instr_data  = instr_data_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;

endmodule
